// File: rtl/apb4_param_regblock.sv
// APB4 slave register block: N_REGS byte-strobed registers with error decode,
// per-register hardware load port and software-write pulses.
module apb4_param_regblock #(
    parameter int unsigned                   N_REGS      = 4,
    parameter int unsigned                   DATA_WIDTH  = 32,
    parameter int unsigned                   ADDR_WIDTH  = 12,
    parameter int unsigned                   REG_STRIDE  = 4,
    parameter logic [N_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    output logic                         PREADY,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PSLVERR,
    input  logic [N_REGS-1:0]            hw_we,
    input  logic [N_REGS*DATA_WIDTH-1:0] hw_wdata,
    output logic [N_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [N_REGS-1:0]            swmod
);

    localparam int unsigned NB     = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(REG_STRIDE);
    localparam int unsigned IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(REG_STRIDE - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StRdResp} state_e;

    state_e                              state_q;
    logic                                wr_q;
    logic [ADDR_WIDTH-1:0]               addr_q;
    logic [DATA_WIDTH-1:0]               wdata_q;
    logic [NB-1:0]                       strb_q;
    logic [DATA_WIDTH-1:0]               rdata_q;
    logic                                rerr_q;

    logic [N_REGS-1:0][DATA_WIDTH-1:0]   regs_q;
    logic [N_REGS-1:0][DATA_WIDTH-1:0]   regs_d;
    logic [N_REGS-1:0]                   swmod_q;
    logic [N_REGS-1:0]                   swmod_d;

    logic [ADDR_WIDTH-1:0]               idx_full;
    logic [IDX_W-1:0]                    idx;
    logic                                addr_ok;
    logic                                sw_wr;

    // Decode works on the captured address so it is stable through the access.
    assign idx_full = addr_q >> OFFS_W;
    assign idx      = idx_full[IDX_W-1:0];
    assign addr_ok  = ((addr_q & OFFS_MASK) == '0) && (idx_full < ADDR_WIDTH'(N_REGS));
    assign sw_wr    = (state_q == StAccess) && wr_q && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (PSEL && !PENABLE) begin
                        wr_q    <= PWRITE;
                        addr_q  <= PADDR;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (wr_q) begin
                        state_q <= StIdle;
                    end else begin
                        rdata_q <= addr_ok ? regs_q[idx] : '0;
                        rerr_q  <= !addr_ok;
                        state_q <= StRdResp;
                    end
                end
                StRdResp: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Hardware load is applied last so it overrides a colliding software write.
    always_comb begin
        regs_d  = regs_q;
        swmod_d = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (sw_wr && (idx == IDX_W'(i))) begin
                swmod_d[i] = 1'b1;
                for (int b = 0; b < int'(NB); b++) begin
                    if (strb_q[b]) begin
                        regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
            if (hw_we[i]) begin
                regs_d[i] = hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= RESET_VALUE;
            swmod_q <= '0;
        end else begin
            regs_q  <= regs_d;
            swmod_q <= swmod_d;
        end
    end

    assign PREADY  = ((state_q == StAccess) && wr_q) || (state_q == StRdResp);
    assign PSLVERR = ((state_q == StAccess) && wr_q && !addr_ok) ||
                     ((state_q == StRdResp) && rerr_q);
    assign PRDATA  = (state_q == StRdResp) ? rdata_q : '0;
    assign reg_q   = regs_q;
    assign swmod   = swmod_q;

endmodule

// File: tb/tb_apb4_param_regblock.sv
// Directed table-driven bench for apb4_param_regblock with hand-written
// sequences for collision, back-to-back and mid-transfer reset.
module tb_apb4_param_regblock;

    localparam logic [127:0] RST_IMG = {32'h44, 32'h33, 32'h22, 32'h11};

    logic         clk;
    logic         rst_n;
    logic         PSEL, PENABLE, PWRITE;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic         PREADY;
    logic [31:0]  PRDATA;
    logic         PSLVERR;
    logic [3:0]   hw_we;
    logic [127:0] hw_wdata;
    logic [127:0] reg_q;
    logic [3:0]   swmod;

    int n_checks = 0;
    int n_pass   = 0;

    apb4_param_regblock #(
        .N_REGS      (4),
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (12),
        .REG_STRIDE  (4),
        .RESET_VALUE (RST_IMG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .hw_we    (hw_we),
        .hw_wdata (hw_wdata),
        .reg_q    (reg_q),
        .swmod    (swmod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called just after a posedge; returns just after the posedge that closes
    // the response cycle, with the bus idle.
    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic err,
                            output int cyc, output logic ok);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        cyc = 2; ok = 1'b0; rd = '0; err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (PREADY) begin
                rd = PRDATA; err = PSLVERR; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
        logic [3:0]  exp_swmod;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] rd;
    logic        err, ok;
    int          cyc, cyc2;

    initial begin
        vecs[0] = '{1'b0, 12'h008, 32'h0,        4'hF, 32'h33,       1'b0, 3, 4'b0000};
        vecs[1] = '{1'b0, 12'h000, 32'h0,        4'hF, 32'h11,       1'b0, 3, 4'b0000};
        vecs[2] = '{1'b1, 12'h004, 32'h11223344, 4'hF, 32'h0,        1'b0, 2, 4'b0010};
        vecs[3] = '{1'b1, 12'h004, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2, 4'b0010};
        vecs[4] = '{1'b0, 12'h004, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 3, 4'b0000};
        vecs[5] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 2, 4'b0000};
        vecs[6] = '{1'b1, 12'h006, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 2, 4'b0000};
        vecs[7] = '{1'b0, 12'h010, 32'h0,        4'hF, 32'h0,        1'b1, 3, 4'b0000};
        vecs[8] = '{1'b0, 12'h004, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 3, 4'b0000};

        rst_n = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        PSTRB = '0; hw_we = '0; hw_wdata = '0;

        @(negedge clk);
        check("rst_reg_q", reg_q, RST_IMG);
        check("rst_pready", PREADY, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_swmod", swmod, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            apb_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, err, cyc, ok);
            check($sformatf("v%0d_ack", v), ok, 1);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
            @(negedge clk);
            check($sformatf("v%0d_swmod", v), swmod, vecs[v].exp_swmod);
            @(negedge clk);
            check($sformatf("v%0d_swmod_off", v), swmod, 0);
            @(posedge clk); #1;
        end
        check("tbl_reg_q", reg_q, {32'h44, 32'h33, 32'h11BB33DD, 32'h11});

        // Collision: hardware load to reg0 during the access cycle of a sw write.
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h000; PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge clk); #1;
        PENABLE = 1; hw_we = 4'b0001; hw_wdata = {96'h0, 32'hCAFEF00D};
        @(negedge clk);
        check("col_pready", PREADY, 1);
        check("col_pslverr", PSLVERR, 0);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 0; hw_we = '0;
        @(negedge clk);
        check("col_swmod", swmod, 4'b0001);
        check("col_reg0", reg_q[31:0], 32'hCAFEF00D);

        // Independent simultaneous hardware loads while idle.
        @(posedge clk); #1;
        hw_we = 4'b0110; hw_wdata = {32'h0, 32'hBBBB2222, 32'hAAAA1111, 32'h0};
        @(posedge clk); #1;
        hw_we = '0;
        @(negedge clk);
        check("hw_multi", reg_q, {32'h44, 32'hBBBB2222, 32'hAAAA1111, 32'hCAFEF00D});
        check("hw_swmod", swmod, 0);

        // Back-to-back write then read with no idle cycle between them.
        @(posedge clk); #1;
        apb_xfer(1'b1, 12'h00C, 32'h5A, 4'hF, rd, err, cyc, ok);
        check("b2b_wr_ack", ok, 1);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'hF, rd, err, cyc2, ok);
        check("b2b_rd_ack", ok, 1);
        check("b2b_wr_cycles", cyc, 2);
        check("b2b_rd_cycles", cyc2, 3);
        check("b2b_rdata", rd, 32'h5A);
        check("b2b_err", err, 0);

        // Reset asserted in the access cycle of a read.
        @(posedge clk); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'h008;
        @(posedge clk); #1;
        PENABLE = 1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mrst_pready", PREADY, 0);
        check("mrst_reg_q", reg_q, RST_IMG);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_idle_pready", PREADY, 0);
        @(negedge clk);
        check("mrst_idle2_pready", PREADY, 0);
        @(posedge clk); #1;
        apb_xfer(1'b0, 12'h008, 32'h0, 4'hF, rd, err, cyc, ok);
        check("mrst_rd_ack", ok, 1);
        check("mrst_rdata", rd, 32'h33);
        check("mrst_err", err, 0);
        check("mrst_cycles", cyc, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb4_param_regblock.md
Name: apb4_param_regblock

Overview:
- Parametrised APB4 slave register block: N_REGS read/write registers of DATA_WIDTH bits at a fixed byte stride.
- Adds four things: byte-strobe writes (PSTRB), PSLVERR on unmapped or misaligned addresses, a per-register hardware write port, and per-register swmod pulses.
- Sits between the APB fabric and the block's datapath: datapath reads reg_q and can load registers through hw_we/hw_wdata.

Parameters:
- N_REGS, 4, number of registers (1..64).
- DATA_WIDTH, 32, register and bus width; multiple of 8.
- ADDR_WIDTH, 12, PADDR width.
- REG_STRIDE, 4, byte distance between registers; power of 2 and at least DATA_WIDTH/8.
- RESET_VALUE, '0, packed N_REGS*DATA_WIDTH reset image; register i uses slice [i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write enables.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  error response.
- hw_we  in  N_REGS  hardware write enable per register.
- hw_wdata  in  N_REGS*DATA_WIDTH  hardware write data, packed.
- reg_q  out  N_REGS*DATA_WIDTH  current register contents, packed.
- swmod  out  N_REGS  one-cycle pulse on an accepted software write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; any transfer in flight is dropped with no PREADY.
  - PREADY=0, PRDATA=0, PSLVERR=0, swmod=0, reg_q=RESET_VALUE.
- Decode:
  - Address is valid iff PADDR % REG_STRIDE == 0 and PADDR/REG_STRIDE < N_REGS; index = PADDR/REG_STRIDE.
  - Any other address is an error.
- FSM states IDLE, ACCESS, RD_RESP:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), capture PWRITE, PADDR, PWDATA, PSTRB and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS, write: PREADY=1 combinationally in this cycle, PSLVERR=1 if the address is invalid. The write commits at the closing edge, then go to IDLE. This gives zero wait states.
  - ACCESS, read: PREADY=0. At the closing edge, register readback (reg value, or 0 if invalid) into PRDATA and the error flag into PSLVERR, then go to RD_RESP.
  - RD_RESP: PREADY=1 with registered PRDATA/PSLVERR, then go to IDLE. This gives one wait state.
  - The FSM completes the transfer even if PSEL drops mid-transfer; this is a protocol violation and no check is made.
- Outputs outside response cycles: PRDATA=0, PSLVERR=0, PREADY=0. Write responses always drive PRDATA=0.
- Software write commit:
  - For each byte b with PSTRB[b]=1, reg[idx] byte b <= PWDATA byte b; other bytes are unchanged.
  - PSTRB=0 is still a valid, acked write: no bytes change, but swmod[idx] still pulses.
  - Invalid address: no register changes, no swmod.
- swmod[idx] is a registered pulse, high for exactly the one cycle after the commit edge, for every accepted valid-address write.
- Hardware write: hw_we[i]=1 loads hw_wdata slice i into reg[i] as a full-width write at the next edge, in any FSM state.
- Collision (hw_we[idx]=1 in the same cycle a software write commits to idx):
  - The hardware write wins for the whole register.
  - The software write is still acked without error, and swmod[idx] still pulses.
- Simultaneous hardware writes to different registers are all applied independently.
- A read whose register is hardware-written during ACCESS returns the pre-edge value.
- Back-to-back transfers: the next setup phase is accepted in the cycle after PREADY; sustained throughput is 2 cycles per write and 3 per read.

Test Plan:
1. Reset with RESET_VALUE image {0x44,0x33,0x22,0x11} (reg3..reg0) -> reg_q matches; read 0x8 returns 0x33 with PREADY on the 3rd cycle from setup and PSLVERR=0.
2. Write 0x4, PWDATA=0xAABBCCDD, PSTRB=4'b0101, reg1 starting at 0x11223344 -> reg1=0x11BB33DD; PREADY in the access cycle; swmod=4'b0010 for exactly one cycle after commit.
3. Error paths: write to 0x10 and to 0x6 (N_REGS=4) -> PSLVERR=1, no reg change, swmod=0. Read 0x10 -> PRDATA=0, PSLVERR=1.
4. Collision: software write 0x0=0x12345678 in the same cycle as hw_we[0]=1 with hw_wdata slice 0=0xCAFEF00D -> reg0=0xCAFEF00D, PREADY=1, PSLVERR=0, swmod[0] pulses.
5. Back-to-back write 0xC=0x5A then read 0xC with no idle cycle -> read returns 0x5A. Write takes 2 cycles and read takes 3.
6. Drive rst_n low during ACCESS of a read -> no PREADY, FSM returns to IDLE, all regs reload RESET_VALUE; the next read after reset release completes normally.
